pcie_cpl_tx: RTL

Completion transmitter for the ECP3 PCIe endpoint's VC0 transmit port. It accepts single-DW completion requests from the BAR-decode/register logic and serializes each one as a 16-bit-wide Completion TLP on the hard core's `tx_req`/`tx_rdy`/`tx_st`/`tx_end`/`tx_data` interface, gated by available completion credits. It is the transmit-side counterpart of the receive TLP path that decodes `rx_st`/`rx_end`/`rx_data` inside `ethpipe_mid`.

---
 rtl/pcie_cpl_tx.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/pcie_cpl_tx.sv
// pcie_cpl_tx: single-DW completion transmitter for the PCIe VC0 TX port.
// Latches one completion request, waits for completion credits, requests
// the core and streams the TLP as 16-bit words. The packet is 8 words for
// CplD and 6 words for an Unsupported Request CPL. Every output is registered.
module pcie_cpl_tx #(
  parameter int CNT_W = 16
) (
  input  logic              clk_125,
  input  logic              sys_rst,
  input  logic [7:0]        bus_num,
  input  logic [4:0]        dev_num,
  input  logic [2:0]        func_num,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_ur,
  input  logic [15:0]       req_rid,
  input  logic [7:0]        req_tag,
  input  logic [6:0]        req_laddr,
  input  logic [31:0]       req_data,
  input  logic [8:0]        tx_ca_cplh,
  input  logic [12:0]       tx_ca_cpld,
  input  logic              tx_rdy,
  output logic              tx_req,
  output logic              tx_st,
  output logic              tx_end,
  output logic [15:0]       tx_data,
  output logic [CNT_W-1:0]  cpl_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_CR = 2'd1,
    S_REQ     = 2'd2,
    S_SEND    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Latched request, held unchanged for the whole TLP
  logic               r_ur,    w_ur_nxt;
  logic [15:0]        r_cid,   w_cid_nxt;
  logic [15:0]        r_rid,   w_rid_nxt;
  logic [7:0]         r_tag,   w_tag_nxt;
  logic [6:0]         r_laddr, w_laddr_nxt;
  logic [31:0]        r_data,  w_data_nxt;

  // Index of the word currently presented on tx_data
  logic [2:0]         r_idx,   w_idx_nxt;

  // Output registers
  logic               r_req_ready, w_req_ready_nxt;
  logic               r_tx_req,    w_tx_req_nxt;
  logic               r_tx_st,     w_tx_st_nxt;
  logic               r_tx_end,    w_tx_end_nxt;
  logic [15:0]        r_tx_data,   w_tx_data_nxt;
  logic [CNT_W-1:0]   r_cpl_cnt,   w_cpl_cnt_nxt;

  logic [2:0]         w_last_idx;
  logic [2:0]         w_idx_inc;
  logic               w_credit_ok;

  // Index of the final word: 5 for a data-less CPL, 7 for CplD
  function automatic logic [2:0] f_last_idx(input logic ur);
    if (ur) begin
      f_last_idx = 3'd5;
    end else begin
      f_last_idx = 3'd7;
    end
  endfunction

  // Completion TLP word generator: 3DW header followed by one data DW
  function automatic logic [15:0] f_cpl_word(
    input logic [2:0]  idx,
    input logic        ur,
    input logic [15:0] cid,
    input logic [15:0] rid,
    input logic [7:0]  tag,
    input logic [6:0]  laddr,
    input logic [31:0] data
  );
    case (idx)
      3'd0:    f_cpl_word = ur ? 16'h0A00 : 16'h4A00;     // fmt/type
      3'd1:    f_cpl_word = ur ? 16'h0000 : 16'h0001;     // length in DW
      3'd2:    f_cpl_word = cid;                          // completer ID
      3'd3:    f_cpl_word = ur ? 16'h2004 : 16'h0004;     // status, BCM, byte count
      3'd4:    f_cpl_word = rid;                          // requester ID
      3'd5:    f_cpl_word = {tag, 1'b0, laddr};           // tag, lower address
      3'd6:    f_cpl_word = data[31:16];
      3'd7:    f_cpl_word = data[15:0];
      default: f_cpl_word = 16'h0000;
    endcase
  endfunction

  assign w_last_idx  = f_last_idx(r_ur);
  assign w_idx_inc   = r_idx + 3'd1;
  // A CPL carries no payload, so only a header credit is needed for it
  assign w_credit_ok = (tx_ca_cplh != 9'd0) && (r_ur || (tx_ca_cpld != 13'd0));

  // Next-state and next-output computation
  always_comb begin
    w_state_nxt     = r_state;
    w_ur_nxt        = r_ur;
    w_cid_nxt       = r_cid;
    w_rid_nxt       = r_rid;
    w_tag_nxt       = r_tag;
    w_laddr_nxt     = r_laddr;
    w_data_nxt      = r_data;
    w_idx_nxt       = r_idx;
    w_req_ready_nxt = r_req_ready;
    w_tx_req_nxt    = r_tx_req;
    w_tx_st_nxt     = r_tx_st;
    w_tx_end_nxt    = r_tx_end;
    w_tx_data_nxt   = r_tx_data;
    w_cpl_cnt_nxt   = r_cpl_cnt;

    case (r_state)
      S_IDLE: begin
        // req_ready is registered, so a request is taken only once it is visible
        if (req_valid && r_req_ready) begin
          w_ur_nxt        = req_ur;
          w_cid_nxt       = {bus_num, dev_num, func_num};
          w_rid_nxt       = req_rid;
          w_tag_nxt       = req_tag;
          w_laddr_nxt     = req_laddr;
          w_data_nxt      = req_data;
          w_req_ready_nxt = 1'b0;
          w_state_nxt     = S_WAIT_CR;
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end

      S_WAIT_CR: begin
        if (w_credit_ok) begin
          w_tx_req_nxt = 1'b1;
          w_state_nxt  = S_REQ;
        end else begin
          w_tx_req_nxt = 1'b0;
        end
      end

      S_REQ: begin
        // Grant: drop the request and present word 0 on the next cycle
        if (tx_rdy) begin
          w_tx_req_nxt  = 1'b0;
          w_idx_nxt     = 3'd0;
          w_tx_st_nxt   = 1'b1;
          w_tx_end_nxt  = 1'b0;
          w_tx_data_nxt = f_cpl_word(3'd0, r_ur, r_cid, r_rid, r_tag, r_laddr, r_data);
          w_state_nxt   = S_SEND;
        end else begin
          w_tx_req_nxt  = 1'b1;
        end
      end

      S_SEND: begin
        // Without tx_rdy the current word, st and end simply hold
        if (tx_rdy) begin
          if (r_idx == w_last_idx) begin
            w_tx_st_nxt     = 1'b0;
            w_tx_end_nxt    = 1'b0;
            w_tx_data_nxt   = 16'h0000;
            w_idx_nxt       = 3'd0;
            w_cpl_cnt_nxt   = r_cpl_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            w_req_ready_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_idx_nxt       = w_idx_inc;
            w_tx_st_nxt     = 1'b0;
            w_tx_end_nxt    = (w_idx_inc == w_last_idx);
            w_tx_data_nxt   = f_cpl_word(w_idx_inc, r_ur, r_cid, r_rid, r_tag, r_laddr, r_data);
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_idx_nxt       = 3'd0;
        w_req_ready_nxt = 1'b0;
        w_tx_req_nxt    = 1'b0;
        w_tx_st_nxt     = 1'b0;
        w_tx_end_nxt    = 1'b0;
        w_tx_data_nxt   = 16'h0000;
      end
    endcase
  end

  // State, latched request and output registers with synchronous reset
  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_ur        <= 1'b0;
      r_cid       <= 16'h0000;
      r_rid       <= 16'h0000;
      r_tag       <= 8'h00;
      r_laddr     <= 7'h00;
      r_data      <= 32'h0000_0000;
      r_idx       <= 3'd0;
      r_req_ready <= 1'b0;
      r_tx_req    <= 1'b0;
      r_tx_st     <= 1'b0;
      r_tx_end    <= 1'b0;
      r_tx_data   <= 16'h0000;
      r_cpl_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_ur        <= w_ur_nxt;
      r_cid       <= w_cid_nxt;
      r_rid       <= w_rid_nxt;
      r_tag       <= w_tag_nxt;
      r_laddr     <= w_laddr_nxt;
      r_data      <= w_data_nxt;
      r_idx       <= w_idx_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_tx_req    <= w_tx_req_nxt;
      r_tx_st     <= w_tx_st_nxt;
      r_tx_end    <= w_tx_end_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_cpl_cnt   <= w_cpl_cnt_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign tx_req    = r_tx_req;
  assign tx_st     = r_tx_st;
  assign tx_end    = r_tx_end;
  assign tx_data   = r_tx_data;
  assign cpl_cnt   = r_cpl_cnt;

endmodule
